cpu_b_control_seq: RTL
======================

// Module: cpu_b_control_seq
// PURPOSE
// - 7-step stepper plus instruction decoder for CPU_B; drives the GPR file directly (s_r0..3, e_r0..3).
// - Also drives the single shared 8-bit bus: IAR, MAR, IR, ACC, TMP and RAM set/enable strobes, bus_1 and the ALU opcode.
// - Each step lasts one clk cycle. Every instruction takes STEPS cycles: fetch in steps 1-3, execute in steps 4-6, idle in step 7.
// PARAMETERS
// - STEPS     7   steps per instruction, legal range 6..8; the counter wraps after step STEPS
// - ALU_OP_W  3   ALU opcode width
// PORTS
// - Clocking is one clock; reset is asynchronous and active-high.
// - clk       in   1         system clock, rising edge
// - reset     in   1         async, active-high
// - en        in   1         run enable; 0 = hold step, all strobes 0
// - ir        in   8         instruction register contents (ra=ir[3:2], rb=ir[1:0])
// - step      out  3         current step, binary 1..STEPS
// - bus_1     out  1         force bus value 8'h01 (IAR increment path)
// - s_r0..s_r3 out 1 each    GPR set strobes
// - e_r0..e_r3 out 1 each    GPR enable-to-bus strobes
// - s_mar, s_ir, s_iar, s_acc, s_tmp, s_ram  out 1 each   register set strobes
// - e_iar, e_acc, e_ram                      out 1 each   bus enable strobes
// - alu_op    out  ALU_OP_W  ALU function; 3'b000 (ADD) unless stated
// BEHAVIOUR
// - State: step register only, async-reset to 1. Outputs are a combinational decode of (step, ir, en, reset).
// - reset=1: step=1, every strobe and alu_op=0. Reset mid-instruction abandons it; the next fetch starts at step 1 in the first cycle after release.
// - en=0: step holds, all strobes 0. en=1: step advances each clk; step STEPS -> 1.
// - Fetch, any ir:
//   - step 1: bus_1, e_iar, s_mar, s_acc, alu_op=ADD
//   - step 2: e_ram, s_ir
//   - step 3: e_acc, s_iar
// - Execute, steps 4/5/6; unlisted steps are all-zero:
//   - ALU (ir[7]=1, op=ir[6:4]): 4: e_rb, s_tmp | 5: e_ra, s_acc, alu_op=op | 6: e_acc, s_rb; step 6 is suppressed when op=3'b111 (CMP)
//   - LD  (ir[7:4]=0000): 4: e_ra, s_mar | 5: e_ram, s_rb
//   - ST  (0001): 4: e_ra, s_mar | 5: e_rb, s_ram
//   - DATA (0010): 4: bus_1, e_iar, s_mar, s_acc, alu_op=ADD | 5: e_ram, s_rb | 6: e_acc, s_iar
//   - JMPR (0011): 4: e_rb, s_iar
//   - 0100..0111: reserved, NOP in steps 4-6
// - Steps >= 7: all strobes 0.
// - ra==rb is legal:
//   - ALU: e_r and s_r of the same GPR occur in different steps.
//   - ST: e_ra and e_rb hit the same GPR in different steps.
// - Invariants, checked by assertion:
//   - At most one of {e_r0..3, e_iar, e_acc, e_ram} is high per cycle.
//   - bus_1 is high only together with e_iar.
//   - The decoded e_r* and s_r* vectors are each one-hot or zero.
// - ir is sampled only in steps 4-6, so changes to ir during steps 1-3 have no effect.
// STRUCTURE
// - Shared package cpu_b_pkg holds:
//   - step constants STEP1..STEP7
//   - opcode nibbles OP_LD, OP_ST, OP_DATA, OP_JMPR, and the ALU-class bit
//   - ALU op codes ALU_ADD..ALU_CMP
// - Sub-module: stepper (counter 1..STEPS, en, async reset). Decode lives in the parent.
// - A 2->4 decode produces the GPR select for ra/rb; the same decode is reused for both set and enable.
// TESTING
// - Reset asserted at step 5 of an ALU op, released -> step=1 next cycle, all strobes 0 during reset.
// - ir=8'h86 (ADD? no: op=000 ra=01 rb=10) steps 4/5/6 -> e_r2,s_tmp | e_r1,s_acc,alu_op=000 | e_acc,s_r2.
// - ir=8'hF5 (CMP r1,r1) -> step 6 all strobes 0; steps 4/5 drive e_r1 only, never s_r1.
// - ir=8'h0E (LD ra=3 rb=2) -> step 4 e_r3,s_mar; step 5 e_ram,s_r2; ir=8'h1B ST -> step 5 e_r3,s_ram.
// - ir=8'h21 (DATA r1) -> step 4 bus_1,e_iar,s_mar,s_acc; step 5 e_ram,s_r1; step 6 e_acc,s_iar.
// - en toggled low at step 3 for 4 cycles -> step stays 3, strobes 0, resumes at step 4; bus-contention assertion is run on random ir for 10k cycles.

Source files
------------

// File: rtl/cpu_b_pkg.sv
// Shared CPU_B constants: step numbers, opcode nibbles, ALU function codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_b_pkg;

  // Step counter is one bit wider than the 3-bit step port so STEPS=8 still counts cleanly.
  localparam int STEP_W = 4;

  localparam logic [STEP_W-1:0] STEP1 = 4'd1;
  localparam logic [STEP_W-1:0] STEP2 = 4'd2;
  localparam logic [STEP_W-1:0] STEP3 = 4'd3;
  localparam logic [STEP_W-1:0] STEP4 = 4'd4;
  localparam logic [STEP_W-1:0] STEP5 = 4'd5;
  localparam logic [STEP_W-1:0] STEP6 = 4'd6;
  localparam logic [STEP_W-1:0] STEP7 = 4'd7;

  // Upper instruction nibble for the non-ALU instruction class.
  localparam logic [3:0] OP_LD   = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0001;
  localparam logic [3:0] OP_DATA = 4'b0010;
  localparam logic [3:0] OP_JMPR = 4'b0011;

  // ir[7] set selects the ALU instruction class.
  localparam int ALU_CLASS_BIT = 7;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SHR = 3'b001,
    ALU_SHL = 3'b010,
    ALU_NOT = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_e;

  // 2->4 register select, shared by the set and enable paths.
  function automatic logic [3:0] dec2to4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/cpu_b_control_seq_stepper.sv
// Step counter 1..STEPS that wraps back to 1; async reset to step 1.
// Latency: step advances one clk after en is seen high.
// Backpressure: en=0 freezes the count.
module cpu_b_control_seq_stepper
  import cpu_b_pkg::*;
#(
  parameter int STEPS = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [STEP_W-1:0] step
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS);

  // Advance while enabled, wrapping the last step back to the first fetch step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step <= STEP1;
    end else if (en) begin
      step <= (step == LAST_STEP) ? STEP1 : step + STEP_W'(1);
    end
  end

endmodule

// File: rtl/cpu_b_control_seq.sv
// CPU_B control sequencer: stepper plus combinational decode of bus/register strobes.
// Latency: strobes are a same-cycle decode of (step, ir, en, reset).
// Backpressure: en=0 holds the step and forces every strobe low.
module cpu_b_control_seq
  import cpu_b_pkg::*;
#(
  parameter int STEPS    = 7,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [7:0]          ir,
  output logic [2:0]          step,
  output logic                bus_1,
  output logic                s_r0,
  output logic                s_r1,
  output logic                s_r2,
  output logic                s_r3,
  output logic                e_r0,
  output logic                e_r1,
  output logic                e_r2,
  output logic                e_r3,
  output logic                s_mar,
  output logic                s_ir,
  output logic                s_iar,
  output logic                s_acc,
  output logic                s_tmp,
  output logic                s_ram,
  output logic                e_iar,
  output logic                e_acc,
  output logic                e_ram,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic [STEP_W-1:0] step_q;
  logic [3:0]        ra_sel;
  logic [3:0]        rb_sel;
  logic [3:0]        s_r;
  logic [3:0]        e_r;
  logic [2:0]        op;

  cpu_b_control_seq_stepper #(
    .STEPS (STEPS)
  ) u_stepper (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .step  (step_q)
  );

  // The port is 3 bits; with STEPS=8 the last step reads back as 0.
  assign step = step_q[2:0];

  assign ra_sel = dec2to4(ir[3:2]);
  assign rb_sel = dec2to4(ir[1:0]);
  assign op     = ir[6:4];

  // Decode the current step and instruction into one cycle's worth of strobes.
  always_comb begin
    bus_1  = 1'b0;
    s_r    = 4'b0000;
    e_r    = 4'b0000;
    s_mar  = 1'b0;
    s_ir   = 1'b0;
    s_iar  = 1'b0;
    s_acc  = 1'b0;
    s_tmp  = 1'b0;
    s_ram  = 1'b0;
    e_iar  = 1'b0;
    e_acc  = 1'b0;
    e_ram  = 1'b0;
    alu_op = ALU_OP_W'(ALU_ADD);
    if (en && !reset) begin
      case (step_q)
        // Fetch: MAR <- IAR and ACC <- IAR+1 share the bus cycle.
        STEP1: begin
          bus_1  = 1'b1;
          e_iar  = 1'b1;
          s_mar  = 1'b1;
          s_acc  = 1'b1;
          alu_op = ALU_OP_W'(ALU_ADD);
        end
        STEP2: begin
          e_ram = 1'b1;
          s_ir  = 1'b1;
        end
        STEP3: begin
          e_acc = 1'b1;
          s_iar = 1'b1;
        end
        STEP4, STEP5, STEP6: begin
          if (ir[ALU_CLASS_BIT]) begin
            case (step_q)
              STEP4: begin
                e_r   = rb_sel;
                s_tmp = 1'b1;
              end
              STEP5: begin
                e_r    = ra_sel;
                s_acc  = 1'b1;
                alu_op = ALU_OP_W'(op);
              end
              default: begin
                // CMP only updates flags; the result is never written back.
                if (op != ALU_CMP) begin
                  e_acc = 1'b1;
                  s_r   = rb_sel;
                end
              end
            endcase
          end else begin
            case (ir[7:4])
              OP_LD: begin
                if (step_q == STEP4) begin
                  e_r   = ra_sel;
                  s_mar = 1'b1;
                end else if (step_q == STEP5) begin
                  e_ram = 1'b1;
                  s_r   = rb_sel;
                end
              end
              OP_ST: begin
                if (step_q == STEP4) begin
                  e_r   = ra_sel;
                  s_mar = 1'b1;
                end else if (step_q == STEP5) begin
                  e_r   = rb_sel;
                  s_ram = 1'b1;
                end
              end
              OP_DATA: begin
                // Immediate byte follows the opcode: re-run the fetch-address sequence.
                if (step_q == STEP4) begin
                  bus_1  = 1'b1;
                  e_iar  = 1'b1;
                  s_mar  = 1'b1;
                  s_acc  = 1'b1;
                  alu_op = ALU_OP_W'(ALU_ADD);
                end else if (step_q == STEP5) begin
                  e_ram = 1'b1;
                  s_r   = rb_sel;
                end else begin
                  e_acc = 1'b1;
                  s_iar = 1'b1;
                end
              end
              OP_JMPR: begin
                if (step_q == STEP4) begin
                  e_r   = rb_sel;
                  s_iar = 1'b1;
                end
              end
              default: begin
                // 0100..0111 reserved: no-op.
              end
            endcase
          end
        end
        STEP7: begin
          // Idle step.
        end
        default: begin
        end
      endcase
    end
  end

  assign {s_r3, s_r2, s_r1, s_r0} = s_r;
  assign {e_r3, e_r2, e_r1, e_r0} = e_r;

  // Single shared bus: never more than one driver.
  a_bus_onehot: assert property (@(posedge clk)
    $onehot0({e_r, e_iar, e_acc, e_ram}));

  // The constant-1 bus path is only used alongside the IAR enable.
  a_bus1_with_iar: assert property (@(posedge clk) bus_1 |-> e_iar);

  // Each GPR select vector addresses at most one register.
  a_gpr_onehot: assert property (@(posedge clk) $onehot0(s_r) && $onehot0(e_r));

endmodule
